// File: rtl/seq_add_mul_pkg.sv
// +-----------------------------------------------------------------------+
// | seq_add_mul_pkg : shared types and constants for seq_add_mul_unit      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package seq_add_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD    = 1'b1;
  localparam logic OP_MUL    = 1'b0;
  localparam int   MAX_WIDTH = 16;

endpackage

`default_nettype wire

// File: rtl/ks_prefix_adder.sv
// +-----------------------------------------------------------------------+
// | ks_prefix_adder : combinational Kogge-Stone parallel-prefix adder      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module ks_prefix_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] prop0;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  assign prop0 = a ^ b;

  // cin is folded into bit 0's generate, so gen[i] ends up as the carry out of bit i
  always_comb begin
    logic [WIDTH-1:0] gen_n;
    logic [WIDTH-1:0] prop_n;
    gen    = a & b;
    prop   = prop0;
    gen[0] = gen[0] | (prop0[0] & cin);
    gen_n  = gen;
    prop_n = prop;
    for (int k = 0; k < LEVELS; k++) begin
      gen_n  = gen;
      prop_n = prop;
      for (int i = (1 << k); i < WIDTH; i++) begin
        gen_n[i]  = gen[i] | (prop[i] & gen[i-(1<<k)]);
        prop_n[i] = prop[i] & prop[i-(1<<k)];
      end
      gen  = gen_n;
      prop = prop_n;
    end
  end

  assign sum  = prop0 ^ {gen[WIDTH-2:0], cin};
  assign cout = gen[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_add_mul_unit.sv
// +-----------------------------------------------------------------------+
// | seq_add_mul_unit : handshaked one-cycle add / iterative shift-add mul  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module seq_add_mul_unit
  import seq_add_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e               state_q,  state_d;
  logic [2*WIDTH-1:0]   p_q,      p_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]     mcand_q,  mcand_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;

  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [2*WIDTH-1:0]   step_p;
  logic                 accept;

  // The single adder serves the MUL step while multiplying and the request operands otherwise
  always_comb begin
    add_a = a;
    add_b = b;
    if (state_q == MUL) begin
      add_a = p_q[2*WIDTH-1:WIDTH];
      add_b = p_q[0] ? mcand_q : '0;
    end
  end

  ks_prefix_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign step_p   = {add_cout, add_sum, p_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    result_d = result_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: ;
      MUL: begin
        p_d   = step_p;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          result_d = step_p;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A request taken in DONE overrides the return to IDLE
    if (accept) begin
      if (op == OP_ADD) begin
        result_d = {{(WIDTH-1){1'b0}}, add_cout, add_sum};
        state_d  = DONE;
      end else begin
        p_d     = {{WIDTH{1'b0}}, b};
        mcand_d = a;
        cnt_d   = '0;
        state_d = MUL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      p_q      <= '0;
      result_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL);
  assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_add_mul_unit.sv
// +-----------------------------------------------------------------------+
// | tb_seq_add_mul_unit : scoreboard bench for WIDTH=8 and WIDTH=3 builds  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_seq_add_mul_unit;
  import seq_add_mul_pkg::*;

  localparam int W   = 8;
  localparam int RW  = 2 * W;
  localparam int W3  = 3;
  localparam int RW3 = 2 * W3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, op, out_valid, out_ready, busy;
  logic [W-1:0]  a, b;
  logic [RW-1:0] result;

  logic           in_valid3, in_ready3, op3, out_valid3, out_ready3, busy3;
  logic [W3-1:0]  a3, b3;
  logic [RW3-1:0] result3;

  logic rand_bp, bp_rdy, rdy_ctl;
  assign out_ready = rand_bp ? bp_rdy : rdy_ctl;

  seq_add_mul_unit #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  seq_add_mul_unit #(.WIDTH(W3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .op(op3),
    .a(a3), .b(b3), .out_valid(out_valid3), .out_ready(out_ready3),
    .result(result3), .busy(busy3)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [RW-1:0]  exp_q[$];
  logic [RW3-1:0] exp3_q[$];
  logic [RW-1:0]  mon_e;
  logic [RW3-1:0] mon_e3;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bp_rdy = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference: plain unsigned arithmetic, wide enough never to overflow
  function automatic int unsigned model(input logic o, input int unsigned x, input int unsigned y);
    return (o == OP_ADD) ? (x + y) : (x * y);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'(out_valid), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("result_w8", 32'(result), 32'(mon_e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid3 && out_ready3) begin
      if (exp3_q.size() == 0) check("unexpected_result_w3", 32'(out_valid3), 32'd0);
      else begin
        mon_e3 = exp3_q.pop_front();
        check("result_w3", 32'(result3), 32'(mon_e3));
      end
    end
  end

  task automatic send(input logic o, input int unsigned x, input int unsigned y, output int acc);
    bit            done;
    logic [RW-1:0] ev;
    done     = 1'b0;
    in_valid = 1'b1;
    op       = o;
    a        = W'(x);
    b        = W'(y);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ev = RW'(model(o, x, y));
        exp_q.push_back(ev);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    acc      = cyc;
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send3(input logic o, input int unsigned x, input int unsigned y);
    bit             done;
    logic [RW3-1:0] ev;
    done      = 1'b0;
    in_valid3 = 1'b1;
    op3       = o;
    a3        = W3'(x);
    b3        = W3'(y);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready3) begin
        ev = RW3'(model(o, x, y));
        exp3_q.push_back(ev);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid3 = 1'b0;
    if (!done) check("accept_timeout_w3", 32'(in_ready3), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp3_q.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(exp_q.size() + exp3_q.size()), 32'd0);
  endtask

  initial begin
    int          acc, acc1, acc2, nb;
    logic        ro;
    int unsigned rx, ry;

    rst       = 1'b1;
    rand_bp   = 1'b0;
    rdy_ctl   = 1'b1;
    in_valid  = 1'b0; op  = 1'b0; a  = '0; b  = '0;
    in_valid3 = 1'b0; op3 = 1'b0; a3 = '0; b3 = '0;
    out_ready3 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_result",    32'(result),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // add latency and carry-out
    send(OP_ADD, 200, 100, acc);
    check("add_lat_valid",  32'(out_valid), 32'd1);
    check("add_lat_result", 32'(result),    32'h012C);
    send(OP_ADD, 255, 255, acc);
    drain();

    // multiply latency and busy window
    send(OP_MUL, 255, 255, acc);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(posedge clk);
      #1;
    end
    check("mul_busy_cycles", 32'(nb),        32'(W));
    check("mul_done_valid",  32'(out_valid), 32'd1);
    check("mul_result",      32'(result),    32'hFE01);
    send(OP_MUL, 0, 173, acc);
    drain();

    // backpressure: result held, new requests ignored
    rdy_ctl = 1'b0;
    send(OP_ADD, 3, 4, acc);
    in_valid = 1'b1; op = OP_MUL; a = 8'd9; b = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result",    32'(result),    32'h0007);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_ctl  = 1'b1;
    drain();

    // back-to-back, accepted in the DONE cycle
    send(OP_ADD, 1, 1, acc1);
    send(OP_MUL, 3, 5, acc2);
    check("b2b_no_bubble", 32'(acc2 - acc1), 32'd1);
    drain();

    // reset in the middle of a multiply
    send(OP_MUL, 200, 200, acc);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy",      32'(busy),      32'd0);
    check("rst_mid_result",    32'(result),    32'd0);
    rst = 1'b0;
    send(OP_MUL, 12, 11, acc);
    drain();

    // random operations under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ro = 1'($urandom_range(0, 1));
      rx = $urandom_range(0, 255);
      ry = $urandom_range(0, 255);
      send(ro, rx, ry, acc);
    end
    @(posedge clk);
    #1;
    rand_bp = 1'b0;
    drain();

    // exhaustive WIDTH=3 sweep
    for (int o = 0; o < 2; o++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++)
          send3(1'(o), x, y);
    drain();
    check("w3_idle_busy", 32'(busy3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
